// File: rtl/cdb_egress_channel.sv
// ---------------------------------------------------------------------------
// cdb_egress_channel
//
// Read/egress end of the CDB asynchronous flit FIFO. The FIFO storage and the
// Johnson write pointer live in the ingress clock domain. This block:
//   - brings the write pointer across with a 2-flop synchroniser,
//   - pops entries and sends them as CHI flits on a credit-controlled TX link,
//   - hands its Johnson read pointer back to the ingress side,
//   - on link deactivation, returns every held L-credit as a link flit
//     (all-zero flit, so the opcode field is zero) and then reports quiescence.
//
// Ports
//   clk_in              egress clock
//   rstn_in             asynchronous active-low reset
//   cdb_fifo_data_in2e  FIFO storage, entry i at [W*(i+1)-1:W*i]
//   wptr_r_in2e         ingress Johnson write pointer (ingress clock domain)
//   rptr_r_e2in         egress Johnson read pointer, straight from the flop
//   tx_flitpend         registered flit-pending hint
//   tx_flitv            registered flit valid
//   tx_flit             registered flit payload (holds while tx_flitv = 0)
//   txcrdv              one L-credit per cycle high
//   link_deact_req      level request to deactivate the link
//   link_deact_done     all credits returned, link quiescent
//   crd_overflow        sticky: credit received with the counter already full
// ---------------------------------------------------------------------------

`ifndef CHANNEL_REQ
`define CHANNEL_REQ 0
`endif
`ifndef CHANNEL_RSP
`define CHANNEL_RSP 1
`endif
`ifndef CHANNEL_SNP
`define CHANNEL_SNP 2
`endif
`ifndef CHANNEL_DAT
`define CHANNEL_DAT 3
`endif

`ifndef DSU_CHI_REQ_FLIT_OPCODE_LEFT
`define DSU_CHI_REQ_FLIT_OPCODE_LEFT 20
`endif
`ifndef DSU_CHI_REQ_FLIT_OPCODE_RIGHT
`define DSU_CHI_REQ_FLIT_OPCODE_RIGHT 14
`endif
`ifndef DSU_CHI_RSP_FLIT_OPCODE_LEFT
`define DSU_CHI_RSP_FLIT_OPCODE_LEFT 8
`endif
`ifndef DSU_CHI_RSP_FLIT_OPCODE_RIGHT
`define DSU_CHI_RSP_FLIT_OPCODE_RIGHT 4
`endif
`ifndef DSU_CHI_SNP_FLIT_OPCODE_LEFT
`define DSU_CHI_SNP_FLIT_OPCODE_LEFT 8
`endif
`ifndef DSU_CHI_SNP_FLIT_OPCODE_RIGHT
`define DSU_CHI_SNP_FLIT_OPCODE_RIGHT 4
`endif
`ifndef DSU_CHI_DAT_FLIT_OPCODE_LEFT
`define DSU_CHI_DAT_FLIT_OPCODE_LEFT 10
`endif
`ifndef DSU_CHI_DAT_FLIT_OPCODE_RIGHT
`define DSU_CHI_DAT_FLIT_OPCODE_RIGHT 7
`endif

// ---------------------------------------------------------------------------
// sync_dff: plain 2-flop synchroniser, reset to zero.
//   clk_in/rstn_in  destination clock and async active-low reset
//   d_i             asynchronous input
//   q_o             synchronised output
// ---------------------------------------------------------------------------
module sync_dff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_in,
   input  logic             rstn_in,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule

module cdb_egress_channel #(
   parameter int CDB_FIFO_DEPTH = 8,
   parameter int CDB_FLIT_WIDTH = 8,
   parameter int CDB_MAX_CRD    = 15,
   parameter int CHANNEL        = 0
) (
   input  logic                                 clk_in,
   input  logic                                 rstn_in,
   input  logic [CDB_FLIT_WIDTH*CDB_FIFO_DEPTH-1:0] cdb_fifo_data_in2e,
   input  logic [CDB_FIFO_DEPTH-1:0]            wptr_r_in2e,
   output logic [CDB_FIFO_DEPTH-1:0]            rptr_r_e2in,
   output logic                                 tx_flitpend,
   output logic                                 tx_flitv,
   output logic [CDB_FLIT_WIDTH-1:0]            tx_flit,
   input  logic                                 txcrdv,
   input  logic                                 link_deact_req,
   output logic                                 link_deact_done,
   output logic                                 crd_overflow
);
   localparam int D  = CDB_FIFO_DEPTH;
   localparam int W  = CDB_FLIT_WIDTH;
   localparam int CW = $clog2(CDB_MAX_CRD + 1);
   localparam logic [CW-1:0] MAX_CRD = CW'(CDB_MAX_CRD);

   // Opcode field position for this channel. A narrow flit clamps the field
   // into range; the link flit is all zeros either way.
   localparam int OPC_LEFT_RAW =
      (CHANNEL == `CHANNEL_RSP) ? `DSU_CHI_RSP_FLIT_OPCODE_LEFT :
      (CHANNEL == `CHANNEL_SNP) ? `DSU_CHI_SNP_FLIT_OPCODE_LEFT :
      (CHANNEL == `CHANNEL_DAT) ? `DSU_CHI_DAT_FLIT_OPCODE_LEFT :
                                  `DSU_CHI_REQ_FLIT_OPCODE_LEFT;
   localparam int OPC_RIGHT_RAW =
      (CHANNEL == `CHANNEL_RSP) ? `DSU_CHI_RSP_FLIT_OPCODE_RIGHT :
      (CHANNEL == `CHANNEL_SNP) ? `DSU_CHI_SNP_FLIT_OPCODE_RIGHT :
      (CHANNEL == `CHANNEL_DAT) ? `DSU_CHI_DAT_FLIT_OPCODE_RIGHT :
                                  `DSU_CHI_REQ_FLIT_OPCODE_RIGHT;
   localparam int OPC_LEFT  = (OPC_LEFT_RAW > W - 1) ? W - 1 : OPC_LEFT_RAW;
   localparam int OPC_RIGHT = (OPC_RIGHT_RAW > OPC_LEFT) ? OPC_LEFT : OPC_RIGHT_RAW;
   localparam logic [OPC_LEFT-OPC_RIGHT:0] LINK_OPCODE = '0;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DEACT = 2'd1,
      ST_STOP  = 2'd2
   } state_t;

   // ---------------- state ----------------
   state_t          state_q, state_d;
   logic [D-1:0]    rptr_q;
   logic [D-1:0]    rptr_oh_q;
   logic [CW-1:0]   crd_cnt_q, crd_cnt_d;
   logic            crd_ovf_q;
   logic            tx_flitv_q;
   logic [W-1:0]    tx_flit_q;
   logic            tx_flitpend_q;
   logic            deact_done_q;

   // ---------------- combinational ----------------
   logic [D-1:0]    sync_wptr;
   logic            empty;
   logic            send_data;
   logic            send_link;
   logic            send_any;
   logic            crd_ovf_set;
   logic [W-1:0]    rd_data;
   logic [W-1:0]    rd_term [D];
   logic [W-1:0]    link_flit;

   sync_dff #(.WIDTH(D)) u_wptr_sync (
      .clk_in  (clk_in),
      .rstn_in (rstn_in),
      .d_i     (wptr_r_in2e),
      .q_o     (sync_wptr)
   );

   // Johnson pointers are equal only when the FIFO is empty; 2*D distinct
   // codes keep full and empty apart without an extra wrap bit.
   assign empty = (rptr_q == sync_wptr);

   // AND-OR read mux: exactly one one-hot bit is set, so no priority chain.
   generate
      for (genvar gi = 0; gi < D; gi++) begin : g_rd_term
         assign rd_term[gi] = cdb_fifo_data_in2e[W*gi +: W] & {W{rptr_oh_q[gi]}};
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < D; i++) begin
         rd_data = rd_data | rd_term[i];
      end
   end

   always_comb begin
      link_flit = '0;
      link_flit[OPC_LEFT:OPC_RIGHT] = LINK_OPCODE;
   end

   always_comb begin
      send_data = (state_q == ST_RUN)   && !empty && (crd_cnt_q != '0);
      send_link = (state_q == ST_DEACT) && (crd_cnt_q != '0);
      send_any  = send_data || send_link;

      // Credit in and flit out in the same cycle cancel out.
      crd_cnt_d   = crd_cnt_q;
      crd_ovf_set = 1'b0;
      if (txcrdv && !send_any) begin
         if (crd_cnt_q == MAX_CRD) begin
            crd_ovf_set = 1'b1;
         end else begin
            crd_cnt_d = crd_cnt_q + CW'(1);
         end
      end else if (!txcrdv && send_any) begin
         crd_cnt_d = crd_cnt_q - CW'(1);
      end

      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            // The send above still happens in the cycle the request arrives.
            if (link_deact_req) state_d = ST_DEACT;
         end
         ST_DEACT: begin
            // Quiescent only once the counter is empty and nothing is arriving.
            if (!link_deact_req) begin
               state_d = ST_RUN;
            end else if ((crd_cnt_q == '0) && !txcrdv) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (!link_deact_req) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         state_q       <= ST_RUN;
         rptr_q        <= '0;
         rptr_oh_q     <= D'(1);
         crd_cnt_q     <= '0;
         crd_ovf_q     <= 1'b0;
         tx_flitv_q    <= 1'b0;
         tx_flit_q     <= '0;
         tx_flitpend_q <= 1'b0;
         deact_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         crd_cnt_q <= crd_cnt_d;
         if (crd_ovf_set) crd_ovf_q <= 1'b1;

         if (send_data) begin
            rptr_q    <= {rptr_q[D-2:0], ~rptr_q[D-1]};
            rptr_oh_q <= {rptr_oh_q[D-2:0], rptr_oh_q[D-1]};
         end

         tx_flitv_q <= send_any;
         if (send_data) begin
            tx_flit_q <= rd_data;
         end else if (send_link) begin
            tx_flit_q <= link_flit;
         end

         tx_flitpend_q <= (state_q != ST_STOP) && (!empty || (state_q == ST_DEACT));
         // Set on the edge that enters STOP, cleared on the edge that leaves it.
         deact_done_q  <= (state_d == ST_STOP);
      end
   end

   assign rptr_r_e2in     = rptr_q;
   assign tx_flitv        = tx_flitv_q;
   assign tx_flit         = tx_flit_q;
   assign tx_flitpend     = tx_flitpend_q;
   assign link_deact_done = deact_done_q;
   assign crd_overflow    = crd_ovf_q;
endmodule

// File: tb/tb_cdb_egress_channel.sv
module tb_cdb_egress_channel;
   logic        clk_in = 1'b0;
   logic        rstn_in;
   logic [63:0] fifo_data;
   logic [7:0]  wptr;
   logic [7:0]  rptr_r_e2in;
   logic        tx_flitpend;
   logic        tx_flitv;
   logic [7:0]  tx_flit;
   logic        txcrdv;
   logic        link_deact_req;
   logic        link_deact_done;
   logic        crd_overflow;

   int          checks = 0;
   int          passes = 0;
   int          cyc    = 0;
   int          widx   = 0;
   logic [7:0]  got [$];
   int          got_cyc [$];

   always #5 clk_in = ~clk_in;

   cdb_egress_channel dut (
      .clk_in             (clk_in),
      .rstn_in            (rstn_in),
      .cdb_fifo_data_in2e (fifo_data),
      .wptr_r_in2e        (wptr),
      .rptr_r_e2in        (rptr_r_e2in),
      .tx_flitpend        (tx_flitpend),
      .tx_flitv           (tx_flitv),
      .tx_flit            (tx_flit),
      .txcrdv             (txcrdv),
      .link_deact_req     (link_deact_req),
      .link_deact_done    (link_deact_done),
      .crd_overflow       (crd_overflow)
   );

   function automatic logic [7:0] johnson(input int n);
      logic [7:0] p;
      p = '0;
      for (int i = 0; i < n; i++) p = {p[6:0], ~p[7]};
      return p;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
         $display("check %s ok: %0h", tag, obs);
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample 1ns after the edge, log every flit seen.
   task automatic tick();
      @(posedge clk_in);
      #1;
      cyc++;
      if (tx_flitv === 1'b1) begin
         got.push_back(tx_flit);
         got_cyc.push_back(cyc);
         $display("cyc %0d flit %02h", cyc, tx_flit);
      end
   endtask

   // Ingress-side write: fill the entry, then advance the Johnson pointer.
   task automatic push(input logic [7:0] v);
      fifo_data[widx*8 +: 8] = v;
      wptr = {wptr[6:0], ~wptr[7]};
      widx = (widx + 1) % 8;
   endtask

   task automatic credit(input int n);
      for (int i = 0; i < n; i++) begin
         txcrdv = 1'b1;
         tick();
      end
      txcrdv = 1'b0;
   endtask

   task automatic clear_log();
      got.delete();
      got_cyc.delete();
   endtask

   initial begin
      int errs;
      rstn_in = 1'b0;
      fifo_data = '0;
      wptr = '0;
      txcrdv = 1'b0;
      link_deact_req = 1'b0;
      repeat (3) tick();
      rstn_in = 1'b1;
      tick();

      // ---- 1: reset state and single-flit latency ----
      check("rst_flitv", 32'(tx_flitv), 32'h0);
      check("rst_flit", 32'(tx_flit), 32'h0);
      check("rst_flitpend", 32'(tx_flitpend), 32'h0);
      check("rst_done", 32'(link_deact_done), 32'h0);
      check("rst_ovf", 32'(crd_overflow), 32'h0);
      check("rst_rptr", 32'(rptr_r_e2in), 32'h00);

      credit(1);
      check("t1_crd1", 32'(dut.crd_cnt_q), 32'd1);
      clear_log();
      push(8'hA5);
      tick();
      tick();
      check("t1_no_early_flit", 32'(got.size()), 32'd0);
      tick();
      check("t1_flitv", 32'(tx_flitv), 32'h1);
      check("t1_flit", 32'(tx_flit), 32'hA5);
      check("t1_rptr", 32'(rptr_r_e2in), 32'h01);
      check("t1_crd0", 32'(dut.crd_cnt_q), 32'd0);
      tick();
      check("t1_flitv_low", 32'(tx_flitv), 32'h0);
      check("t1_flit_hold", 32'(tx_flit), 32'hA5);
      check("t1_one_pulse", 32'(got.size()), 32'd1);

      // ---- 2: credit stall ----
      clear_log();
      push(8'h11); tick();
      push(8'h22); tick();
      push(8'h33); tick();
      repeat (6) tick();
      check("t2_stalled", 32'(got.size()), 32'd0);
      check("t2_flitpend", 32'(tx_flitpend), 32'h1);
      credit(2);
      repeat (4) tick();
      check("t2_two_sent", 32'(got.size()), 32'd2);
      check("t2_first", 32'(got[0]), 32'h11);
      check("t2_second", 32'(got[1]), 32'h22);
      credit(1);
      repeat (4) tick();
      check("t2_three_sent", 32'(got.size()), 32'd3);
      check("t2_third", 32'(got[2]), 32'h33);
      check("t2_flitpend_idle", 32'(tx_flitpend), 32'h0);

      // ---- 3: wrap-around, 20 flits 0..19 (24 pops in total) ----
      clear_log();
      credit(10);
      for (int i = 0; i < 20; i++) begin
         push(8'(i));
         txcrdv = (i < 10);
         tick();
      end
      txcrdv = 1'b0;
      repeat (6) tick();
      check("t3_count", 32'(got.size()), 32'd20);
      errs = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== 8'(i)) errs++;
      check("t3_sequence_errs", 32'(errs), 32'd0);
      check("t3_crd0", 32'(dut.crd_cnt_q), 32'd0);
      check("t3_rptr", 32'(rptr_r_e2in), 32'(johnson(24)));

      // ---- 4: back-to-back with a full FIFO ----
      clear_log();
      for (int i = 0; i < 8; i++) begin
         push(8'h40 + 8'(i));
         tick();
      end
      repeat (4) tick();
      check("t4_stalled", 32'(got.size()), 32'd0);
      credit(15);
      repeat (4) tick();
      check("t4_count", 32'(got.size()), 32'd8);
      errs = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== (8'h40 + 8'(i))) errs++;
      check("t4_sequence_errs", 32'(errs), 32'd0);
      if (got.size() == 8)
         check("t4_consecutive_span", 32'(got_cyc[7] - got_cyc[0]), 32'd7);
      check("t4_crd7", 32'(dut.crd_cnt_q), 32'd7);
      check("t4_rptr_wrap", 32'(rptr_r_e2in), 32'h00);

      // ---- 5: credit overflow ----
      credit(8);
      check("t5_crd_max", 32'(dut.crd_cnt_q), 32'd15);
      check("t5_ovf_clear", 32'(crd_overflow), 32'h0);
      credit(1);
      check("t5_crd_held", 32'(dut.crd_cnt_q), 32'd15);
      check("t5_ovf_set", 32'(crd_overflow), 32'h1);
      repeat (3) tick();
      check("t5_ovf_sticky", 32'(crd_overflow), 32'h1);
      rstn_in = 1'b0;
      #1;
      check("t5_ovf_async_rst", 32'(crd_overflow), 32'h0);
      check("t5_crd_async_rst", 32'(dut.crd_cnt_q), 32'd0);
      fifo_data = '0;
      wptr = '0;
      widx = 0;
      repeat (2) tick();
      rstn_in = 1'b1;
      tick();

      // ---- 6: link deactivation ----
      clear_log();
      credit(3);
      push(8'h77);
      link_deact_req = 1'b1;
      tick();
      push(8'h88);
      repeat (6) tick();
      check("t6_link_count", 32'(got.size()), 32'd3);
      errs = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== 8'h00) errs++;
      check("t6_link_nonzero", 32'(errs), 32'd0);
      if (got.size() == 3)
         check("t6_link_span", 32'(got_cyc[2] - got_cyc[0]), 32'd2);
      check("t6_done", 32'(link_deact_done), 32'h1);
      check("t6_flitpend_stop", 32'(tx_flitpend), 32'h0);
      check("t6_no_pop", 32'(rptr_r_e2in), 32'h00);
      check("t6_crd0", 32'(dut.crd_cnt_q), 32'd0);
      link_deact_req = 1'b0;
      txcrdv = 1'b1;
      tick();
      check("t6_done_clear", 32'(link_deact_done), 32'h0);
      tick();
      txcrdv = 1'b0;
      repeat (5) tick();
      check("t6_total", 32'(got.size()), 32'd5);
      if (got.size() == 5) begin
         check("t6_data0", 32'(got[3]), 32'h77);
         check("t6_data1", 32'(got[4]), 32'h88);
      end
      check("t6_rptr", 32'(rptr_r_e2in), 32'(johnson(2)));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
